// File: rtl/key_search_scheduler.sv
// Round-robin key dispatcher for an array of RC4 decrypt cores: hands out candidate
// keys, tracks per-core ownership, latches the first passing key or reports exhaustion.
module key_search_scheduler #(
    parameter int                 NUM_CORES = 4,
    parameter int                 KEY_WIDTH = 24,
    parameter logic [KEY_WIDTH:0] KEY_LIMIT = 'h400000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_CORES-1:0] core_idle,
    input  logic [NUM_CORES-1:0] core_done,
    input  logic [NUM_CORES-1:0] core_pass,
    output logic [NUM_CORES-1:0] core_start,
    output logic [KEY_WIDTH-1:0] core_key,
    output logic                 core_abort,
    output logic                 busy,
    output logic                 found,
    output logic                 exhausted,
    output logic [KEY_WIDTH-1:0] found_key,
    output logic [KEY_WIDTH:0]   keys_tried
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEARCH,
        S_DRAIN,
        S_FOUND,
        S_EXHAUSTED
    } state_t;

    state_t               state_q, state_d;
    logic [KEY_WIDTH:0]   next_key_q, next_key_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_CORES-1:0] assigned_q, assigned_d;
    logic [KEY_WIDTH-1:0] key_reg_q [NUM_CORES];
    logic [KEY_WIDTH-1:0] key_reg_d [NUM_CORES];
    logic [NUM_CORES-1:0] core_start_q, core_start_d;
    logic [KEY_WIDTH-1:0] core_key_q, core_key_d;
    logic                 core_abort_q, core_abort_d;
    logic                 busy_q, busy_d;
    logic                 found_q, found_d;
    logic                 exhausted_q, exhausted_d;
    logic [KEY_WIDTH-1:0] found_key_q, found_key_d;
    logic [KEY_WIDTH:0]   keys_tried_q, keys_tried_d;

    logic [NUM_CORES-1:0] accepted;
    logic [NUM_CORES-1:0] passing;
    logic [NUM_CORES-1:0] eligible;
    logic                 running;
    logic                 any_pass;
    logic                 grant_vld;
    logic [IDX_W-1:0]     grant_idx;
    logic [IDX_W-1:0]     pass_idx;
    int                   cand;

    function automatic logic [KEY_WIDTH:0] popcount(input logic [NUM_CORES-1:0] v);
        logic [KEY_WIDTH:0] n;
        n = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            n = n + {{KEY_WIDTH{1'b0}}, v[i]};
        end
        return n;
    endfunction

    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_CORES-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    // Done pulses only count against cores that actually own a key.
    always_comb begin
        running  = (state_q == S_SEARCH) || (state_q == S_DRAIN);
        accepted = (state_q != S_IDLE) ? (core_done & assigned_q) : '0;
        passing  = accepted & core_pass;
        any_pass = running && (passing != '0);
        pass_idx = lowest_set(passing);
        eligible = core_idle & ~assigned_q;
    end

    // Walk offsets from high to low so the nearest eligible core at/after rr_ptr wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            cand = (int'(rr_ptr_q) + k) % NUM_CORES;
            if (eligible[IDX_W'(cand)]) begin
                grant_vld = 1'b1;
                grant_idx = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        next_key_d   = next_key_q;
        rr_ptr_d     = rr_ptr_q;
        assigned_d   = assigned_q & ~accepted;
        key_reg_d    = key_reg_q;
        core_start_d = '0;
        core_key_d   = core_key_q;
        core_abort_d = core_abort_q;
        found_d      = found_q;
        exhausted_d  = exhausted_q;
        found_key_d  = found_key_q;
        keys_tried_d = keys_tried_q;

        if (running) begin
            keys_tried_d = keys_tried_q + popcount(accepted);
        end

        if (!running) begin
            if (start) begin
                state_d      = S_SEARCH;
                next_key_d   = '0;
                assigned_d   = '0;
                keys_tried_d = '0;
                found_d      = 1'b0;
                exhausted_d  = 1'b0;
                found_key_d  = '0;
                core_abort_d = 1'b0;
            end
        end else if (any_pass) begin
            state_d      = S_FOUND;
            found_d      = 1'b1;
            core_abort_d = 1'b1;
            found_key_d  = key_reg_q[pass_idx];
            assigned_d   = '0;
        end else if (state_q == S_SEARCH) begin
            if (grant_vld) begin
                core_start_d[grant_idx] = 1'b1;
                core_key_d              = next_key_q[KEY_WIDTH-1:0];
                key_reg_d[grant_idx]    = next_key_q[KEY_WIDTH-1:0];
                assigned_d[grant_idx]   = 1'b1;
                next_key_d              = next_key_q + 1'b1;
                rr_ptr_d                = (grant_idx == IDX_W'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;
                if (next_key_q + 1'b1 == KEY_LIMIT) state_d = S_DRAIN;
            end
        end else if (assigned_d == '0) begin
            state_d     = S_EXHAUSTED;
            exhausted_d = 1'b1;
        end

        busy_d = (state_d == S_SEARCH) || (state_d == S_DRAIN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            next_key_q   <= '0;
            rr_ptr_q     <= '0;
            assigned_q   <= '0;
            for (int i = 0; i < NUM_CORES; i++) key_reg_q[i] <= '0;
            core_start_q <= '0;
            core_key_q   <= '0;
            core_abort_q <= 1'b0;
            busy_q       <= 1'b0;
            found_q      <= 1'b0;
            exhausted_q  <= 1'b0;
            found_key_q  <= '0;
            keys_tried_q <= '0;
        end else begin
            state_q      <= state_d;
            next_key_q   <= next_key_d;
            rr_ptr_q     <= rr_ptr_d;
            assigned_q   <= assigned_d;
            key_reg_q    <= key_reg_d;
            core_start_q <= core_start_d;
            core_key_q   <= core_key_d;
            core_abort_q <= core_abort_d;
            busy_q       <= busy_d;
            found_q      <= found_d;
            exhausted_q  <= exhausted_d;
            found_key_q  <= found_key_d;
            keys_tried_q <= keys_tried_d;
        end
    end

    assign core_start = core_start_q;
    assign core_key   = core_key_q;
    assign core_abort = core_abort_q;
    assign busy       = busy_q;
    assign found      = found_q;
    assign exhausted  = exhausted_q;
    assign found_key  = found_key_q;
    assign keys_tried = keys_tried_q;

endmodule

// File: tb/tb_key_search_scheduler.sv
// Scoreboard bench for key_search_scheduler: behavioural cores with per-core latency,
// expected dispatches (core, key, cycle offset from start) queued and checked by a monitor.
module tb_key_search_scheduler;

    localparam int NC = 4;
    localparam int KW = 24;

    typedef struct {
        int core;
        int key;
        int off;
    } exp_t;
    typedef int arr8_t [8];

    logic          clk;
    logic          reset;
    logic          start;
    logic [NC-1:0] core_idle;
    logic [NC-1:0] core_done;
    logic [NC-1:0] core_pass;
    logic [NC-1:0] core_start;
    logic [KW-1:0] core_key;
    logic          core_abort;
    logic          busy;
    logic          found;
    logic          exhausted;
    logic [KW-1:0] found_key;
    logic [KW:0]   keys_tried;

    exp_t          sbq[$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            start_cyc = 0;
    int            end_off = 0;
    logic [NC-1:0] idle_mask = '1;
    logic [NC-1:0] spur = '0;
    logic [7:0]    pass_keys = '0;
    int            lat [NC];
    int            cnt [NC];
    logic [KW-1:0] held [NC];

    key_search_scheduler #(
        .NUM_CORES(NC),
        .KEY_WIDTH(KW),
        .KEY_LIMIT(25'd8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .core_idle(core_idle),
        .core_done(core_done),
        .core_pass(core_pass),
        .core_start(core_start),
        .core_key(core_key),
        .core_abort(core_abort),
        .busy(busy),
        .found(found),
        .exhausted(exhausted),
        .found_key(found_key),
        .keys_tried(keys_tried)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int c, input int k, input int o);
        exp_t e;
        e.core = c;
        e.key  = k;
        e.off  = o;
        sbq.push_back(e);
    endtask

    task automatic push_run(input arr8_t cores, input arr8_t offs);
        for (int i = 0; i < 8; i++) push(cores[i], i, offs[i]);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_end(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(found || exhausted) && n < 100);
        check(name, 32'(found || exhausted), 1);
        end_off = cyc - start_cyc;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_core_start"}, 32'(core_start), 0);
        check({tag, "_core_key"}, 32'(core_key), 0);
        check({tag, "_abort"}, 32'(core_abort), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_found"}, 32'(found), 0);
        check({tag, "_exhausted"}, 32'(exhausted), 0);
        check({tag, "_found_key"}, 32'(found_key), 0);
        check({tag, "_keys_tried"}, 32'(keys_tried), 0);
    endtask

    // Behavioural cores: done pulse sampled lat[i] edges after the dispatch edge.
    initial begin
        logic [NC-1:0] busy_c;
        core_done = '0;
        core_pass = '0;
        core_idle = '0;
        for (int i = 0; i < NC; i++) begin
            cnt[i]  = 0;
            held[i] = '0;
        end
        forever begin
            @(negedge clk);
            core_done = '0;
            core_pass = '0;
            busy_c    = '0;
            for (int i = 0; i < NC; i++) begin
                if (reset || core_abort) begin
                    cnt[i] = 0;
                end else begin
                    if (cnt[i] > 0) begin
                        cnt[i]--;
                        if (cnt[i] == 0) begin
                            core_done[i] = 1'b1;
                            core_pass[i] = pass_keys[held[i][2:0]];
                        end
                    end
                    if (core_start[i]) begin
                        cnt[i]  = lat[i] - 1;
                        held[i] = core_key;
                    end
                end
                busy_c[i] = (cnt[i] > 0);
            end
            core_done = core_done | spur;
            core_idle = idle_mask & ~busy_c;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (core_start != '0) begin
                if (sbq.size() == 0) begin
                    check("unexpected_start", 32'(core_start), 0);
                end else begin
                    e = sbq.pop_front();
                    check("start_core", 32'(core_start), 32'(1 << e.core));
                    check("start_key", 32'(core_key), 32'(e.key));
                    check("start_cycle", 32'(cyc - start_cyc), 32'(e.off));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        arr8_t c;
        arr8_t o;
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < NC; i++) lat[i] = 3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_zero("reset");

        // Full sweep, every key fails.
        c = '{0, 1, 2, 3, 0, 1, 2, 3};
        o = '{1, 2, 3, 4, 5, 6, 7, 8};
        push_run(c, o);
        do_start();
        @(negedge clk);
        check("t1_busy", 32'(busy), 1);
        wait_end("t1_end_seen");
        check("t1_exhausted", 32'(exhausted), 1);
        check("t1_found", 32'(found), 0);
        check("t1_keys_tried", 32'(keys_tried), 8);
        check("t1_end_cycle", 32'(end_off), 11);
        check("t1_busy_end", 32'(busy), 0);

        // Key 6 on core 2 passes.
        pass_keys = 8'b0100_0000;
        push_run(c, o);
        do_start();
        wait_end("t2_end_seen");
        check("t2_found", 32'(found), 1);
        check("t2_found_key", 32'(found_key), 6);
        check("t2_abort", 32'(core_abort), 1);
        check("t2_exhausted", 32'(exhausted), 0);
        check("t2_keys_tried", 32'(keys_tried), 7);
        check("t2_end_cycle", 32'(end_off), 10);
        repeat (6) @(negedge clk);
        check("t2_abort_held", 32'(core_abort), 1);
        check("t2_queue_empty", 32'(sbq.size()), 0);

        // Restart from FOUND; cores 1 and 3 pass together with keys 5 and 7.
        lat[0] = 3; lat[1] = 4; lat[2] = 3; lat[3] = 2;
        pass_keys = 8'b1010_0000;
        c = '{0, 1, 2, 3, 0, 1, 2, 3};
        o = '{1, 2, 3, 4, 5, 7, 8, 9};
        push_run(c, o);
        do_start();
        @(negedge clk);
        check("t3_found_clr", 32'(found), 0);
        check("t3_abort_clr", 32'(core_abort), 0);
        check("t3_key_clr", 32'(found_key), 0);
        check("t3_tried_clr", 32'(keys_tried), 0);
        check("t3_busy", 32'(busy), 1);
        wait_end("t3_end_seen");
        check("t3_found", 32'(found), 1);
        check("t3_found_key", 32'(found_key), 5);
        check("t3_keys_tried", 32'(keys_tried), 8);
        check("t3_end_cycle", 32'(end_off), 11);

        // Only core 2 idle, core 0 joins later; spurious done on core 1.
        for (int i = 0; i < NC; i++) lat[i] = 3;
        pass_keys = '0;
        idle_mask = 4'b0100;
        c = '{2, 2, 0, 2, 0, 2, 0, 2};
        o = '{1, 5, 7, 9, 11, 13, 15, 17};
        push_run(c, o);
        do_start();
        repeat (2) @(posedge clk);
        spur = 4'b0010;
        @(posedge clk);
        spur = '0;
        @(negedge clk);
        check("t4_spurious_done", 32'(keys_tried), 0);
        repeat (3) @(posedge clk);
        idle_mask = 4'b0101;
        wait_end("t4_end_seen");
        check("t4_exhausted", 32'(exhausted), 1);
        check("t4_found", 32'(found), 0);
        check("t4_keys_tried", 32'(keys_tried), 8);
        check("t4_end_cycle", 32'(end_off), 20);

        // Start ignored mid-search, then asynchronous reset with 3 cores assigned.
        idle_mask = 4'b1111;
        push(3, 0, 1);
        push(0, 1, 2);
        push(1, 2, 3);
        push(2, 3, 4);
        do_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("t5_keys_tried", 32'(keys_tried), 1);
        check("t5_busy", 32'(busy), 1);
        #1 reset = 1'b1;
        #1 check_zero("t5_async");
        @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_zero("t5_after");
        repeat (4) @(negedge clk);
        check("t5_idle_busy", 32'(busy), 0);
        check("t5_queue_empty", 32'(sbq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
